// File: rtl/sfr_arbiter.sv
// Round-robin arbiter sharing one SFR slave port between NUM_M masters, with a
// single outstanding read, response routing to the issuing master and a response watchdog.
module sfr_arbiter #(
  parameter int          NUM_M     = 2,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEADDEAD
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [32*NUM_M-1:0] m_addr_i,
  input  logic [4*NUM_M-1:0]  m_be_i,
  input  logic [32*NUM_M-1:0] m_wdata_i,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_resp_o,
  output logic [31:0]         m_rdata_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [31:0]         s_addr_o,
  output logic [3:0]          s_be_o,
  output logic [31:0]         s_wdata_o,
  input  logic                s_ack_i,
  input  logic                s_resp_i,
  input  logic [31:0]         s_rdata_i,
  output logic                timeout_o,
  output logic                state_o
);
  localparam int IW = $clog2(NUM_M);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT_RESP = 1'b1} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [WW-1:0] wdog;
  logic [IW-1:0] winner;
  logic [IW-1:0] rr_next;
  logic          accept;
  logic          rd_accept;

  assign state_o = (state == WAIT_RESP);

  // First requester at or after rr_ptr, ascending with wrap.
  always_comb begin
    logic found;
    int   j;
    found  = 1'b0;
    winner = rr_ptr;
    for (int i = 0; i < NUM_M; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_M) j = j - NUM_M;
      if (!found && m_req_i[j]) begin
        found  = 1'b1;
        winner = IW'(j);
      end
    end
  end

  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (winner == IW'(k)) begin
        s_we_o    = m_we_i[k];
        s_addr_o  = m_addr_i[32*k +: 32];
        s_be_o    = m_be_i[4*k +: 4];
        s_wdata_o = m_wdata_i[32*k +: 32];
      end
    end
  end

  // Handshake: a command transfers in the cycle s_req_o && s_ack_i; the winning
  // master sees m_ack_o in that same cycle and may then drop or change its request.
  // While a read waits for data nothing is issued, except in the s_resp_i cycle.
  assign s_req_o   = (|m_req_i) && !(state == WAIT_RESP && !s_resp_i);
  assign accept    = s_req_o && s_ack_i;
  assign rd_accept = accept && !s_we_o;
  assign rr_next   = (winner == IW'(NUM_M - 1)) ? '0 : winner + IW'(1);

  always_comb begin
    m_ack_o = '0;
    if (accept) m_ack_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      wdog      <= '0;
      m_resp_o  <= '0;
      m_rdata_o <= '0;
      timeout_o <= 1'b0;
    end else begin
      m_resp_o  <= '0;
      timeout_o <= 1'b0;
      if (accept) rr_ptr <= rr_next;
      case (state)
        IDLE: begin
          if (rd_accept) begin
            owner <= winner;
            wdog  <= '0;
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          wdog <= wdog + WW'(1);
          if (s_resp_i) begin
            m_resp_o[owner] <= 1'b1;
            m_rdata_o       <= s_rdata_i;
            if (rd_accept) begin
              owner <= winner;
              wdog  <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            m_resp_o[owner] <= 1'b1;
            m_rdata_o       <= ERR_RDATA;
            timeout_o       <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sfr_arbiter.sv
// Directed, table-driven bench for sfr_arbiter (NUM_M=2, TIMEOUT=16) with
// hand-written sequences for the watchdog and the asynchronous reset.
module tb_sfr_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  m_req_i = '0;
  logic [1:0]  m_we_i = '0;
  logic [63:0] m_addr_i = {32'h0000_0200, 32'h0000_0100};
  logic [7:0]  m_be_i = 8'hFF;
  logic [63:0] m_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
  logic [1:0]  m_ack_o;
  logic [1:0]  m_resp_o;
  logic [31:0] m_rdata_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_ack_i = 1'b0;
  logic        s_resp_i = 1'b0;
  logic [31:0] s_rdata_i = '0;
  logic        timeout_o;
  logic        state_o;

  int total = 0;
  int bad = 0;

  sfr_arbiter #(.NUM_M(2), .TIMEOUT(16), .ERR_RDATA(32'hDEADDEAD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
    .timeout_o(timeout_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic        sack;
    logic        sresp;
    logic [31:0] rdata;
    logic [1:0]  eack;
    logic        esreq;
    logic [31:0] esaddr;
    logic [1:0]  eresp;
    logic [31:0] erdata;
    logic        etout;
    logic        ebusy;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic [1:0] req, logic [1:0] we, logic sack, logic sresp,
                              logic [31:0] rdata, logic [1:0] eack, logic esreq,
                              logic [31:0] esaddr, logic [1:0] eresp, logic [31:0] erdata,
                              logic etout, logic ebusy);
    vec_t v;
    v.req = req; v.we = we; v.sack = sack; v.sresp = sresp; v.rdata = rdata;
    v.eack = eack; v.esreq = esreq; v.esaddr = esaddr; v.eresp = eresp;
    v.erdata = erdata; v.etout = etout; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic sack,
                       input logic sresp, input logic [31:0] rdata);
    m_req_i = req; m_we_i = we; s_ack_i = sack; s_resp_i = sresp; s_rdata_i = rdata;
  endtask

  initial begin
    // Stimulus table: inputs | ack, s_req, s_addr, resp, rdata, timeout, busy
    vecs[0]  = mk(2'b00, 2'b00, 0, 0, 0,            2'b00, 0, 0,     2'b00, 0,            0, 0);
    vecs[1]  = mk(2'b01, 2'b00, 1, 0, 0,            2'b01, 1, 'h100, 2'b00, 0,            0, 0);
    vecs[2]  = mk(2'b00, 2'b00, 0, 1, 'hDEADBEEF,   2'b00, 0, 0,     2'b00, 0,            0, 1);
    vecs[3]  = mk(2'b00, 2'b00, 0, 0, 0,            2'b00, 0, 0,     2'b01, 'hDEADBEEF,   0, 0);
    vecs[4]  = mk(2'b11, 2'b11, 1, 0, 0,            2'b10, 1, 'h200, 2'b00, 'hDEADBEEF,   0, 0);
    vecs[5]  = mk(2'b11, 2'b11, 1, 0, 0,            2'b01, 1, 'h100, 2'b00, 'hDEADBEEF,   0, 0);
    vecs[6]  = mk(2'b11, 2'b11, 1, 0, 0,            2'b10, 1, 'h200, 2'b00, 'hDEADBEEF,   0, 0);
    vecs[7]  = mk(2'b11, 2'b11, 1, 0, 0,            2'b01, 1, 'h100, 2'b00, 'hDEADBEEF,   0, 0);
    vecs[8]  = mk(2'b01, 2'b00, 1, 0, 0,            2'b01, 1, 'h100, 2'b00, 'hDEADBEEF,   0, 0);
    vecs[9]  = mk(2'b10, 2'b00, 1, 1, 'h11111111,   2'b10, 1, 'h200, 2'b00, 'hDEADBEEF,   0, 1);
    vecs[10] = mk(2'b00, 2'b00, 0, 1, 'h22222222,   2'b00, 0, 0,     2'b01, 'h11111111,   0, 1);
    vecs[11] = mk(2'b00, 2'b00, 0, 0, 0,            2'b00, 0, 0,     2'b10, 'h22222222,   0, 0);
    vecs[12] = mk(2'b10, 2'b00, 1, 0, 0,            2'b10, 1, 'h200, 2'b00, 'h22222222,   0, 0);
    vecs[13] = mk(2'b01, 2'b01, 1, 0, 0,            2'b00, 0, 0,     2'b00, 'h22222222,   0, 1);
    vecs[14] = mk(2'b01, 2'b01, 1, 0, 0,            2'b00, 0, 0,     2'b00, 'h22222222,   0, 1);
    vecs[15] = mk(2'b01, 2'b01, 1, 1, 'h33333333,   2'b01, 1, 'h100, 2'b00, 'h22222222,   0, 1);
    vecs[16] = mk(2'b00, 2'b00, 0, 0, 0,            2'b00, 0, 0,     2'b10, 'h33333333,   0, 0);
    vecs[17] = mk(2'b11, 2'b11, 0, 0, 0,            2'b00, 1, 'h200, 2'b00, 'h33333333,   0, 0);
    vecs[18] = mk(2'b11, 2'b11, 1, 0, 0,            2'b10, 1, 'h200, 2'b00, 'h33333333,   0, 0);
    vecs[19] = mk(2'b00, 2'b00, 0, 1, 'h44444444,   2'b00, 0, 0,     2'b00, 'h33333333,   0, 0);
    vecs[20] = mk(2'b00, 2'b00, 0, 0, 0,            2'b00, 0, 0,     2'b00, 'h33333333,   0, 0);

    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].sack, vecs[i].sresp, vecs[i].rdata);
      @(negedge clk_i);
      chk("ack", i, 32'(m_ack_o), 32'(vecs[i].eack));
      chk("s_req", i, 32'(s_req_o), 32'(vecs[i].esreq));
      if (vecs[i].esreq) chk("s_addr", i, s_addr_o, vecs[i].esaddr);
      chk("resp", i, 32'(m_resp_o), 32'(vecs[i].eresp));
      chk("rdata", i, m_rdata_o, vecs[i].erdata);
      chk("timeout", i, 32'(timeout_o), 32'(vecs[i].etout));
      chk("busy", i, 32'(state_o), 32'(vecs[i].ebusy));
      @(posedge clk_i); #1;
    end

    // Watchdog: M0 read never answered; error response 16 edges after accept.
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("to_ack", 0, 32'(m_ack_o), 32'h1);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i); #1;
      chk("to_resp", k, 32'(m_resp_o), (k == 16) ? 32'h1 : 32'h0);
      chk("to_pulse", k, 32'(timeout_o), (k == 16) ? 32'h1 : 32'h0);
      if (k == 16) chk("to_rdata", k, m_rdata_o, 32'hDEADDEAD);
      if (k == 18) drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h55555555);
      if (k == 19) begin
        chk("late_rdata", k, m_rdata_o, 32'hDEADDEAD);
        drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      end
    end
    chk("to_idle", 0, 32'(state_o), 32'h0);

    // Reset mid-read: M0 read leaves rr_ptr at 1, then reset must clear everything.
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_resp", 0, 32'(m_resp_o), 32'h0);
    chk("rst_rdata", 0, m_rdata_o, 32'h0);
    chk("rst_timeout", 0, 32'(timeout_o), 32'h0);
    chk("rst_ack", 0, 32'(m_ack_o), 32'h0);
    chk("rst_sreq", 0, 32'(s_req_o), 32'h0);
    chk("rst_busy", 0, 32'(state_o), 32'h0);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h66666666);
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i); #1;
    chk("post_rst_resp", 0, 32'(m_resp_o), 32'h0);
    drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("post_rst_tie", 0, 32'(m_ack_o), 32'h1);
    @(posedge clk_i); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i); #1;
    chk("post_rst_wr_resp", 0, 32'(m_resp_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
